fp_norm_round: RTL and testbench

- Two-stage pipelined normalize-and-round unit for the single-precision FP adder datapath.
- It consumes the raw 32-bit adder sum together with the leading-zero anticipator's shift amount and direction.
- It applies the shift, corrects the anticipator's one-bit misprediction, and rounds to nearest-even.
- It produces a packed IEEE-754 binary32 result with overflow, underflow and zero flags; valid/ready handshakes are on both sides.

---
 rtl/fp_norm_round.sv | 143 ++++++++++++++
 tb/tb_fp_norm_round.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// Two-stage normalize-and-round for the binary32 adder: stage 1 applies the LZA shift
// and one-bit correction, stage 2 rounds to nearest-even and packs with exception flags.
module fp_norm_round #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_sum,
  input  logic [4:0]       s_shift,
  input  logic             s_shift_right,
  input  logic [EXP_W-1:0] s_exp,
  input  logic             s_sign,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_result,
  output logic             m_ovf,
  output logic             m_uf,
  output logic             m_zero
);

  localparam int unsigned EW = 10;  // signed exponent, two's complement
  localparam int unsigned TW = 25;  // normalized significand t[24:0]
  localparam int unsigned MW = 24;
  localparam int unsigned FW = 23;

  typedef struct packed {
    logic          sign;
    logic          zero;
    logic          sticky;
    logic [EW-1:0] e;
    logic [TW-1:0] t;
  } s1_t;

  logic             v1_q, v2_q;
  logic             adv1, adv2;
  s1_t              s1_d, s1_q;
  logic [WIDTH-1:0] sh_t, lost_mask;
  logic             sh_sticky;
  logic [EW-1:0]    sh_e;

  logic [MW-1:0]    mant;
  logic             guard, rnd_up, frac_co, mant_co;
  logic [FW-1:0]    frac;
  logic [EW-1:0]    e2;
  logic             e_ovf, e_uf;
  logic [31:0]      m_result_d, m_result_q;
  logic             m_ovf_d, m_ovf_q, m_uf_d, m_uf_q, m_zero_d, m_zero_q;

  assign adv2     = !v2_q || m_ready;
  assign adv1     = !v1_q || adv2;
  assign s_ready  = adv1;
  assign m_valid  = v2_q;
  assign m_result = m_result_q;
  assign m_ovf    = m_ovf_q;
  assign m_uf     = m_uf_q;
  assign m_zero   = m_zero_q;

  // Stage 1: shift, then fix the anticipator's possible off-by-one
  always_comb begin
    lost_mask = ~({WIDTH{1'b1}} << s_shift);
    sh_t      = s_sum << s_shift;
    sh_sticky = 1'b0;
    sh_e      = EW'(s_exp) - EW'(s_shift);
    if (s_shift_right) begin
      sh_t      = s_sum >> s_shift;
      sh_sticky = |(s_sum & lost_mask);
      sh_e      = EW'(s_exp) + EW'(s_shift);
    end

    s1_d.sign   = s_sign;
    s1_d.zero   = (s_sum == '0);
    s1_d.sticky = sh_sticky;
    s1_d.e      = sh_e;
    s1_d.t      = sh_t[TW-1:0];
    if (|sh_t[WIDTH-1:TW]) begin
      s1_d.t      = sh_t[TW:1];
      s1_d.sticky = sh_sticky | sh_t[0];
      s1_d.e      = sh_e + EW'(1);
    end else if (!sh_t[TW-1] && sh_t[TW-2]) begin
      s1_d.t = {sh_t[TW-2:0], 1'b0};
      s1_d.e = sh_e - EW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      s1_q <= '0;
    end else if (adv1) begin
      v1_q <= s_valid;
      if (s_valid) s1_q <= s1_d;
    end
  end

  // Stage 2: round to nearest-even; a carry out of the fraction renormalizes to 1.0
  always_comb begin
    mant              = s1_q.t[TW-1:1];
    guard             = s1_q.t[0];
    rnd_up            = guard & (s1_q.sticky | mant[0]);
    {frac_co, frac}   = {1'b0, mant[FW-1:0]} + MW'(rnd_up);
    mant_co           = frac_co & mant[MW-1];
    e2                = s1_q.e + EW'(mant_co);
    e_ovf             = !e2[EW-1] && (e2[EW-2:0] >= 9'd255);
    e_uf              = e2[EW-1] || (e2 == '0);

    m_result_d = {s1_q.sign, e2[7:0], frac};
    m_ovf_d    = 1'b0;
    m_uf_d     = 1'b0;
    m_zero_d   = 1'b0;
    if (s1_q.zero) begin
      m_result_d = {s1_q.sign, 31'b0};
      m_zero_d   = 1'b1;
    end else if (e_ovf) begin
      m_result_d = {s1_q.sign, 8'hFF, 23'b0};
      m_ovf_d    = 1'b1;
    end else if (e_uf) begin
      m_result_d = {s1_q.sign, 31'b0};
      m_uf_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q       <= 1'b0;
      m_result_q <= '0;
      m_ovf_q    <= 1'b0;
      m_uf_q     <= 1'b0;
      m_zero_q   <= 1'b0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        m_result_q <= m_result_d;
        m_ovf_q    <= m_ovf_d;
        m_uf_q     <= m_uf_d;
        m_zero_q   <= m_zero_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: expected beats queued on input accept,
// popped and compared when the output handshake completes.
module tb_fp_norm_round;

  typedef struct packed {
    logic [31:0] r;
    logic        ovf;
    logic        uf;
    logic        zero;
  } exp_t;

  localparam logic L = 1'b0;
  localparam logic R = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_shift_right, s_sign;
  logic [31:0] s_sum;
  logic [4:0]  s_shift;
  logic [7:0]  s_exp;
  logic        m_valid, m_ready, m_ovf, m_uf, m_zero;
  logic [31:0] m_result;

  exp_t sb[$];
  exp_t pend;
  exp_t got;
  int   total = 0;
  int   bad = 0;
  int   accepted = 0;
  bit   rand_done;

  always #5 clk = ~clk;

  fp_norm_round #(.WIDTH(32), .EXP_W(8)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_sum(s_sum), .s_shift(s_shift),
    .s_shift_right(s_shift_right), .s_exp(s_exp), .s_sign(s_sign),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
    .m_ovf(m_ovf), .m_uf(m_uf), .m_zero(m_zero)
  );

  // Output side of the scoreboard
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got r=%h with no beat outstanding", m_result);
      end else begin
        got = sb.pop_front();
        if ({m_result, m_ovf, m_uf, m_zero} !== got) begin
          bad++;
          $display("FAIL out_beat: got r=%h ovf=%b uf=%b zero=%b want r=%h ovf=%b uf=%b zero=%b",
                   m_result, m_ovf, m_uf, m_zero, got.r, got.ovf, got.uf, got.zero);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] r, input logic o, input logic u, input logic z);
    mk = {r, o, u, z};
  endfunction

  // Reference: 64-bit fixed point with 32 fraction bits below the sum
  function automatic exp_t model(input logic [31:0] sum, input logic [4:0] sh, input logic right,
                                 input logic [7:0] ex, input logic sg);
    exp_t        o;
    int          e;
    logic [63:0] x, tmp;
    logic [31:0] t;
    logic        st, g;
    logic [24:0] m;
    o = '0;
    if (sum == 32'd0) begin
      o.r    = {sg, 31'b0};
      o.zero = 1'b1;
      return o;
    end
    if (right) begin
      x = {sum, 32'b0} >> sh;
      e = int'(ex) + int'(sh);
    end else begin
      tmp = {32'b0, sum} << sh;
      x   = {tmp[31:0], 32'b0};
      e   = int'(ex) - int'(sh);
    end
    t  = x[63:32];
    st = |x[31:0];
    if (t[31:25] != 7'd0) begin
      m  = {1'b0, t[25:2]};
      g  = t[1];
      st = st | t[0];
      e++;
    end else if (!t[24] && t[23]) begin
      m = {1'b0, t[23:0]};
      g = 1'b0;
      e--;
    end else begin
      m = {1'b0, t[24:1]};
      g = t[0];
    end
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = 25'h0800000;
      e++;
    end
    if (e >= 255) begin
      o.r   = {sg, 8'hFF, 23'b0};
      o.ovf = 1'b1;
    end else if (e <= 0) begin
      o.r  = {sg, 31'b0};
      o.uf = 1'b1;
    end else begin
      o.r = {sg, 8'(e), m[22:0]};
    end
    return o;
  endfunction

  task automatic set_beat(input logic [31:0] sum, input logic [4:0] sh, input logic right,
                          input logic [7:0] ex, input logic sg, input exp_t want);
    s_sum         = sum;
    s_shift       = sh;
    s_shift_right = right;
    s_exp         = ex;
    s_sign        = sg;
    s_valid       = 1'b1;
    pend          = want;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin
        sb.push_back(pend);
        accepted++;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL accept_timeout: s_ready=%b want 1 within 50 cycles", s_ready);
  endtask

  task automatic send(input logic [31:0] sum, input logic [4:0] sh, input logic right,
                      input logic [7:0] ex, input logic sg, input exp_t want);
    @(posedge clk);
    #1;
    set_beat(sum, sh, right, ex, sg, want);
    wait_accept();
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    total++;
    bad++;
    $display("FAIL drain_timeout: %0d beats outstanding, want 0", sb.size());
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    s_sum = '0; s_shift = '0; s_shift_right = 1'b0; s_exp = '0; s_sign = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_mvalid: got %b want 0", m_valid); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_sready: got %b want 1", s_ready); end
    total++; if (m_result !== 32'h0) begin bad++; $display("FAIL rst_result: got %h want 0", m_result); end
    total++;
    if ({m_ovf, m_uf, m_zero} !== 3'b000) begin
      bad++; $display("FAIL rst_flags: got %b want 000", {m_ovf, m_uf, m_zero});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    m_ready = 1'b1;
    send(32'h01000000, 5'd0,  L, 8'd127, 1'b0, mk(32'h3F800000, 0, 0, 0));
    send(32'h00000001, 5'd24, L, 8'd127, 1'b0, mk(32'h33800000, 0, 0, 0));
    send(32'h03000003, 5'd1,  R, 8'd127, 1'b0, mk(32'h40400001, 0, 0, 0));
    send(32'h01000001, 5'd0,  L, 8'd127, 1'b0, mk(32'h3F800000, 0, 0, 0));
    send(32'h01000003, 5'd0,  L, 8'd127, 1'b0, mk(32'h3F800002, 0, 0, 0));
    send(32'h01FFFFFF, 5'd0,  L, 8'd127, 1'b0, mk(32'h40000000, 0, 0, 0));
    send(32'h00800000, 5'd0,  L, 8'd127, 1'b0, mk(32'h3F000000, 0, 0, 0));
    send(32'h03000000, 5'd1,  R, 8'd254, 1'b0, mk(32'h7F800000, 1, 0, 0));
    send(32'h00000001, 5'd24, L, 8'd10,  1'b0, mk(32'h00000000, 0, 1, 0));
    send(32'h00000000, 5'd3,  R, 8'd127, 1'b1, mk(32'h80000000, 0, 0, 1));
    send(32'h01000000, 5'd0,  L, 8'd127, 1'b1, mk(32'hBF800000, 0, 0, 0));
    send(32'h03000000, 5'd1,  R, 8'd254, 1'b1, mk(32'hFF800000, 1, 0, 0));
    send(32'h04000006, 5'd2,  R, 8'd127, 1'b0, mk(32'h40800001, 0, 0, 0));
    send(32'h02000003, 5'd0,  R, 8'd127, 1'b0, mk(32'h40000001, 0, 0, 0));
    send(32'h01000000, 5'd0,  L, 8'd254, 1'b0, mk(32'h7F000000, 0, 0, 0));
    send(32'h01000000, 5'd0,  L, 8'd255, 1'b0, mk(32'h7F800000, 1, 0, 0));
    send(32'h01000000, 5'd0,  L, 8'd1,   1'b0, mk(32'h00800000, 0, 0, 0));
    send(32'h01000000, 5'd0,  L, 8'd0,   1'b0, mk(32'h00000000, 0, 1, 0));
    idle();
    wait_drain();
  endtask

  task automatic test_latency();
    m_ready = 1'b1;
    send(32'h01000003, 5'd0, L, 8'd127, 1'b0, mk(32'h3F800002, 0, 0, 0));
    idle();
    @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got m_valid=%b want 0", m_valid); end
    @(negedge clk);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL lat_due: got m_valid=%b want 1", m_valid); end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int base;
    m_ready = 1'b0;
    base = accepted;
    send(32'h01000000, 5'd0,  L, 8'd127, 1'b0, mk(32'h3F800000, 0, 0, 0));
    send(32'h00000001, 5'd24, L, 8'd127, 1'b0, mk(32'h33800000, 0, 0, 0));
    @(posedge clk);
    #1;
    set_beat(32'h03000003, 5'd1, R, 8'd127, 1'b0, mk(32'h40400001, 0, 0, 0));
    @(negedge clk);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_sready: got %b want 0", s_ready); end
    total++;
    if (accepted - base != 2) begin
      bad++; $display("FAIL bp_accepted: got %0d want 2", accepted - base);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (m_valid !== 1'b1 || m_result !== 32'h3F800000 || s_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: got v=%b r=%h rdy=%b want v=1 r=3f800000 rdy=0",
                 m_valid, m_result, s_ready);
      end
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_accept();
    idle();
    wait_drain();
  endtask

  task automatic test_random();
    int          p, mode;
    logic [31:0] one, sum;
    logic [4:0]  sh;
    logic        right, sg;
    logic [7:0]  ex;
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          p   = $urandom_range(31, 0);
          one = 32'd1 << p;
          sum = one | ($urandom() & (one - 32'd1));
          if (p >= 25) begin
            right = 1'b1;
            sh    = 5'(p - 24 - int'($urandom_range(1, 0)));
          end else begin
            right = 1'b0;
            mode  = $urandom_range(2, 0);
            if (p == 24 && mode == 0) mode = 1;
            sh = 5'(23 - p + mode);
          end
          if ($urandom_range(15, 0) == 0) sum = 32'd0;
          ex = 8'($urandom_range(255, 0));
          sg = 1'($urandom_range(1, 0));
          send(sum, sh, right, ex, sg, model(sum, sh, right, ex, sg));
        end
        idle();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          m_ready = ($urandom_range(3, 0) != 0);
        end
      end
    join
    m_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bit seen;
    m_ready = 1'b0;
    send(32'h01000000, 5'd0,  L, 8'd127, 1'b0, mk(32'h3F800000, 0, 0, 0));
    send(32'h00000001, 5'd24, L, 8'd127, 1'b0, mk(32'h33800000, 0, 0, 0));
    idle();
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL rstm_pre: got m_valid=%b want 1", m_valid); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rstm_mvalid: got %b want 0", m_valid); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rstm_sready: got %b want 1", s_ready); end
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstm_ghost: got m_valid seen=%b want 0", seen); end
    send(32'h01000001, 5'd0, L, 8'd127, 1'b0, mk(32'h3F800000, 0, 0, 0));
    idle();
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_latency();
    test_backpressure();
    test_random();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
